// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, state and response definitions for the ALU issue controller.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 5;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_ADDSUB = 4'd1;
    localparam logic [3:0] OP_LSH    = 4'd2;
    localparam logic [3:0] OP_ASH    = 4'd3;
    localparam logic [3:0] OP_LOAD   = 4'd4;
    localparam logic [3:0] OP_LESS   = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd9;
    localparam logic [3:0] OP_NOR    = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              err;
    } rsp_t;

    // Function codes that are sent to the ALU for execution.
    function automatic logic is_alu_op(input logic [3:0] fn);
        return (fn == OP_MUL) || (fn == OP_ADDSUB) || (fn == OP_LSH) || (fn == OP_ASH) ||
               (fn == OP_LESS) || (fn == OP_OR) || (fn == OP_NOR);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] fn);
        return is_alu_op(fn) || (fn == OP_LOAD);
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// Operand register file: two combinational read ports, one synchronous write port, r0 reads zero.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 8,
    localparam int unsigned IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rs1,
    input  logic [IDX_W-1:0]  rs2,
    output logic [DATA_W-1:0] rd1_c,
    output logic [DATA_W-1:0] rd2_c,
    input  logic              we,
    input  logic [IDX_W-1:0]  wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1_c = (rs1 == '0) ? '0 : mem[rs1];
    assign rd2_c = (rs2 == '0) ? '0 : mem[rs2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues requests to the combinational two-lane ALU and returns responses.
// Optional ALU_OP_COUNT_EN adds op_count/err_count response counters.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NREG     = 8,
    parameter int unsigned MUL_WAIT = 2,
    localparam int unsigned IDX_W   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [IDX_W-1:0]  req_rd,
    input  logic [IDX_W-1:0]  req_rs1,
    input  logic [IDX_W-1:0]  req_rs2,
    input  logic [DATA_W-1:0] req_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err
`ifdef ALU_OP_COUNT_EN
    ,
    output logic [15:0]       op_count,
    output logic [7:0]        err_count
`endif
);

    localparam int unsigned CNT_W = $clog2(MUL_WAIT + 2);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_d, alu_b_d;
    logic [OP_W-1:0]   alu_sel_d;
    logic              rsp_valid_d, req_ready_d;
    rsp_t              rsp_q, rsp_d;
    logic              accept_c;
    logic              we_c;
    logic [IDX_W-1:0]  wa_c;
    logic [DATA_W-1:0] wd_c;
    logic [DATA_W-1:0] rs1_data_c, rs2_data_c;

    alu_ctrl_regfile #(.NREG(NREG)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .rs1   (req_rs1),
        .rs2   (req_rs2),
        .rd1_c (rs1_data_c),
        .rd2_c (rs2_data_c),
        .we    (we_c),
        .wa    (wa_c),
        .wd    (wd_c)
    );

    assign accept_c = req_valid && req_ready;

    // Next-state, register-file write and output computation.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_sel_d   = alu_sel;
        rsp_valid_d = rsp_valid;
        rsp_d       = rsp_q;
        we_c        = 1'b0;
        wa_c        = rd_q;
        wd_c        = alu_out;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    rd_d = req_rd;
                    if (!is_legal_op(req_op[3:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_d       = '{data: '0, zero: 1'b0, err: 1'b1};
                    end else if (req_op[3:0] == OP_LOAD) begin
                        we_c        = 1'b1;
                        wa_c        = req_rd;
                        wd_c        = req_imm;
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_d       = '{data: req_imm, zero: (req_imm == '0), err: 1'b0};
                    end else begin
                        state_d   = EXEC;
                        alu_a_d   = rs1_data_c;
                        alu_b_d   = rs2_data_c;
                        alu_sel_d = req_op;
                        cnt_d     = (req_op[3:0] == OP_MUL) ? CNT_W'(MUL_WAIT) : '0;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    we_c        = 1'b1;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_d       = '{data: alu_out, zero: alu_zero, err: 1'b0};
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            cnt_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            req_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_sel   <= alu_sel_d;
            rsp_valid <= rsp_valid_d;
            rsp_q     <= rsp_d;
            req_ready <= req_ready_d;
        end
    end

    assign rsp_data = rsp_q.data;
    assign rsp_zero = rsp_q.zero;
    assign rsp_err  = rsp_q.err;

`ifdef ALU_OP_COUNT_EN
    // Completed-response counters: good ops wrap, errors saturate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_q.err) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else begin
                op_count <= op_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a transaction-level register model.
module tb_alu_issue_ctrl;

    localparam int unsigned NREG     = 8;
    localparam int unsigned MUL_WAIT = 2;
    localparam int unsigned IDX_W    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_op = '0;
    logic [IDX_W-1:0] req_rd = '0;
    logic [IDX_W-1:0] req_rs1 = '0;
    logic [IDX_W-1:0] req_rs2 = '0;
    logic [31:0]      req_imm = '0;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [4:0]       alu_sel;
    logic [31:0]      alu_out;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
`ifdef ALU_OP_COUNT_EN
    logic [15:0]      op_count;
    logic [7:0]       err_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] model_reg [NREG];
    logic [31:0] last_data;
    logic        last_zero;
    logic        last_err;

    always #5 clk = ~clk;

    // Reference two-lane ALU: each 16-bit half evaluated separately.
    function automatic logic [31:0] alu_fn(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [15:0] x, y, z;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            x = a[l*16 +: 16];
            y = b[l*16 +: 16];
            case (sel[3:0])
                4'd0:    z = 16'(x * y);
                4'd1:    z = sel[4] ? 16'(x - y) : 16'(x + y);
                4'd2:    z = sel[4] ? (x >> y[3:0]) : (x << y[3:0]);
                4'd3:    z = 16'($signed(x) >>> y[3:0]);
                4'd5:    z = {15'd0, sel[4] ? (x < y) : ($signed(x) < $signed(y))};
                4'd9:    z = x | y;
                4'd11:   z = ~(x | y);
                default: z = '0;
            endcase
            r[l*16 +: 16] = z;
        end
        return r;
    endfunction

    assign alu_out  = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_zero = (alu_out == 32'h0);

    alu_issue_ctrl #(.NREG(NREG), .MUL_WAIT(MUL_WAIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
`ifdef ALU_OP_COUNT_EN
        ,
        .op_count  (op_count),
        .err_count (err_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%08h exp=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One request/response transaction, checked every cycle from accept to handshake.
    task automatic do_req(input logic [4:0] op, input int rd, input int rs1, input int rs2,
                          input logic [31:0] imm, input int hold);
        logic [31:0] ea, eb, ed;
        logic ez, ee;
        int lat;
        bit is_alu;
        ea = (rs1 == 0) ? 32'h0 : model_reg[rs1];
        eb = (rs2 == 0) ? 32'h0 : model_reg[rs2];
        is_alu = op[3:0] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11};
        if (op[3:0] == 4'd4) begin
            lat = 1; ed = imm; ez = (imm == 32'h0); ee = 1'b0;
        end else if (is_alu) begin
            lat = (op[3:0] == 4'd0) ? 2 + int'(MUL_WAIT) : 2;
            ed = alu_fn(op, ea, eb); ez = (ed == 32'h0); ee = 1'b0;
        end else begin
            lat = 1; ed = 32'h0; ez = 1'b0; ee = 1'b1;
        end

        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = IDX_W'(rd);
        req_rs1   = IDX_W'(rs1);
        req_rs2   = IDX_W'(rs2);
        req_imm   = imm;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 5'($urandom);
        req_rd    = IDX_W'($urandom);
        req_rs1   = IDX_W'($urandom);
        req_rs2   = IDX_W'($urandom);
        req_imm   = $urandom;

        for (int c = 1; c < lat; c++) begin
            chk("exec_rsp_valid", rsp_valid, 0);
            chk("exec_req_ready", req_ready, 0);
            chk("exec_alu_a", alu_a, ea);
            chk("exec_alu_b", alu_b, eb);
            chk("exec_alu_sel", 32'(alu_sel), 32'(op));
            @(negedge clk);
        end

        for (int h = 0; h <= hold; h++) begin
            if (h == 0) begin
                last_data = rsp_data;
                last_zero = rsp_zero;
                last_err  = rsp_err;
            end
            chk("resp_valid", rsp_valid, 1);
            chk("resp_data", rsp_data, ed);
            chk("resp_zero", rsp_zero, ez);
            chk("resp_err", rsp_err, ee);
            chk("resp_req_ready", req_ready, 0);
            if (h == hold) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0;

        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        if (is_alu) chk("post_alu_a_held", alu_a, ea);
        if ((is_alu || op[3:0] == 4'd4) && rd != 0) model_reg[rd] = ed;
    endtask

    task automatic rand_req();
        logic [4:0] op;
        logic [3:0] legal [8];
        logic [31:0] imm;
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd11};
        if ($urandom_range(0, 9) < 8) op = {1'($urandom), legal[$urandom_range(0, 7)]};
        else                          op = 5'($urandom);
        imm = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        do_req(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), imm,
               $urandom_range(0, 3));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(NREG); i++) model_reg[i] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", 32'(alu_sel), 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);

        // LOAD + ADD
        do_req(5'd4, 1, 0, 0, 32'h0000_0005, 0);
        do_req(5'd4, 2, 0, 0, 32'h0000_0003, 0);
        do_req(5'b00001, 3, 1, 2, 32'h0, 0);
        chk("lit_add_data", last_data, 32'h0000_0008);
        chk("lit_add_zero", last_zero, 0);

        // MUL latency and operand stability
        do_req(5'd0, 4, 1, 2, 32'h0, 1);
        chk("lit_mul_data", last_data, 32'h0000_000F);

        // Illegal op leaves rd untouched
        do_req(5'b00110, 3, 1, 2, 32'h1234_5678, 0);
        chk("lit_ill_data", last_data, 32'h0);
        chk("lit_ill_err", last_err, 1);
        do_req(5'd9, 0, 3, 0, 32'h0, 0);
        chk("lit_ill_rd_kept", last_data, 32'h0000_0008);

        // r0 write discarded, response still carries value
        do_req(5'd4, 0, 0, 0, 32'hDEAD_BEEF, 0);
        chk("lit_r0_load", last_data, 32'hDEAD_BEEF);
        do_req(5'd9, 6, 0, 0, 32'h0, 0);
        chk("lit_r0_or", last_data, 32'h0);
        chk("lit_r0_zero", last_zero, 1);

        // Backpressure
        do_req(5'd11, 7, 1, 2, 32'h0, 5);
        chk("lit_nor_data", last_data, 32'hFFFF_FFF8);

        // Same source and destination uses old value
        do_req(5'd1, 1, 1, 1, 32'h0, 0);
        chk("lit_rs_eq_rd", last_data, 32'h0000_000A);

        for (int n = 0; n < 300; n++) rand_req();

        // Reset in the second MUL EXEC cycle
        chk("mul_rst_ready", req_ready, 1);
        req_valid = 1'b1; req_op = 5'd0; req_rd = 3'd5; req_rs1 = 3'd1; req_rs2 = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mul_rst_exec1_a", alu_a, model_reg[1]);
        @(negedge clk);
        chk("mul_rst_exec2_valid", rsp_valid, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_sel", 32'(alu_sel), 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_req_ready", req_ready, 1);
        for (int i = 0; i < int'(NREG); i++) model_reg[i] = 32'h0;
        for (int i = 1; i < int'(NREG); i++) begin
            do_req(5'd9, 0, i, 0, 32'h0, 0);
            chk("lit_cleared_reg", last_data, 32'h0);
        end

        for (int n = 0; n < 100; n++) rand_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator-side controller for the two-lane 16-bit ALU. It accepts operation requests over a valid/ready handshake and keeps a small operand register file. It drives the ALU's A, B and select inputs, waits the required settle time, captures the result and zero flag, writes the destination register, and returns a response over a second valid/ready handshake. It sits between the MCU decode stage and the combinational ALU.

Parameters:
NREG, 8, number of 32-bit operand registers; index width is clog2(NREG); r0 reads as zero.
MUL_WAIT, 2, extra settle cycles held in EXEC when op[3:0] is the multiply code.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_op  input  5  [3:0] ALU function code, [4] ALU modifier bit
req_rd  input  clog2(NREG)  destination register index
req_rs1  input  clog2(NREG)  source register for ALU A
req_rs2  input  clog2(NREG)  source register for ALU B
req_imm  input  32  immediate for the LOAD op
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_sel  output  5  ALU select
alu_out  input  32  ALU result
alu_zero  input  1  ALU zero flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  result or immediate written to rd
rsp_zero  output  1  rsp_data == 0
rsp_err  output  1  illegal op; nothing written

Behaviour:
- Function codes, op[3:0]:
  - ALU-executed: 0 MUL, 1 ADD/SUB, 2 LSHIFT, 3 ASHIFT, 5 LESS, 9 OR, 11 NOR.
  - Handled locally, never issued to the ALU: 4 LOAD.
  - All other codes are illegal.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, rd, rs1, rs2 and imm.
  - Illegal op: go to RESP with rsp_err=1, rsp_data=0, rsp_zero=0; register file unchanged.
  - LOAD: write imm to rd in the accept cycle. Go to RESP with rsp_data=imm, rsp_zero=(imm==0), rsp_err=0.
  - ALU op: go to EXEC, loading alu_a=reg[rs1], alu_b=reg[rs2], alu_sel=op. These outputs are registered and valid from the first EXEC cycle.
- EXEC:
  - req_ready=0.
  - Hold alu_a, alu_b and alu_sel stable for the whole state.
  - Dwell is 1 cycle, or 1+MUL_WAIT cycles for MUL, counted by a down-counter.
  - On the last EXEC cycle, sample alu_out and alu_zero into rsp_data and rsp_zero, write alu_out to rd, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_zero and rsp_err are held until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE. The next request is accepted no earlier than the following cycle.
- Latency, accept to rsp_valid: LOAD and illegal ops 1 cycle; ALU ops 2 cycles; MUL 2+MUL_WAIT cycles.
- r0:
  - Reads always return 0.
  - Writes to r0 are discarded, but the response still carries the computed value.
- Source read with rs==rd: use the old value. The write occurs only at the end of EXEC.
- Outside EXEC, alu_a, alu_b and alu_sel hold their last values.
- Reset (rst_n=0 at a clock edge, in any state including mid-EXEC or mid-RESP):
  - State=IDLE, all registers cleared to 0.
  - alu_a=0, alu_b=0, alu_sel=0.
  - rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0.
  - req_ready=0 during reset, 1 on the first cycle after release.
- The lane semantics of the ALU (independent 16-bit halves) are not interpreted; results pass through unmodified.

Optional Feature:
ALU_OP_COUNT_EN:
- With the macro defined, adds output op_count[15:0]:
  - increments on each rsp handshake with rsp_err=0;
  - wraps 0xFFFF to 0x0000;
  - resets to 0.
- Adds output err_count[7:0]: increments on each handshake with rsp_err=1, saturates at 0xFF.
- Without the macro, neither port nor the counters exist and behaviour is otherwise identical.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode constants OP_MUL=0, OP_ADDSUB=1, OP_LSH=2, OP_ASH=3, OP_LOAD=4, OP_LESS=5, OP_OR=9, OP_NOR=11;
  - state typedef {IDLE, EXEC, RESP};
  - a legal-op function.
- Sub-module alu_ctrl_regfile: NREG x 32 storage, two combinational read ports, one synchronous write port, r0 forced to zero, synchronous clear on rst_n.

Test Plan:
1. LOAD r1=0x0000_0005, then r2=0x0000_0003; ADD op=5'b00001 rd=3 rs1=1 rs2=2; real ALU attached -> rsp_data=ALU result, matching lane-wise 0x0000_0008; rsp_zero=0; alu_sel=5'b00001 held for exactly 1 EXEC cycle.
2. MUL op=0 with MUL_WAIT=2 -> EXEC lasts 3 cycles, rsp_valid exactly 4 cycles after accept, alu_a/alu_b stable throughout.
3. Illegal op=5'b00110 -> rsp_err=1, rsp_data=0, one cycle after accept; a subsequent read of rd shows its prior value.
4. LOAD r0=0xDEAD_BEEF -> rsp_data=0xDEAD_BEEF; a following OR rs1=0 rs2=0 -> rsp_data=0, rsp_zero=1.
5. Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle.
6. Assert rst_n=0 during the second MUL EXEC cycle -> next cycle state IDLE, rsp_valid=0, alu outputs 0, all registers read 0.
